// File: rtl/reg_view_pkg.sv
// Shared types and constants for the register-viewer controller.
package reg_view_pkg;

    // Width of the register index presented on reg_index / rd_addr.
    localparam int REG_IDX_W = 5;

    // Largest value the 4-digit decimal display can show.
    localparam logic [15:0] DISPLAY_MAX = 16'd9999;

    // Read sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_CAPTURE = 2'd2
    } view_state_t;

    // Saturate an unsigned 32-bit register value to the display range.
    function automatic logic [15:0] clamp_display(input logic [31:0] value);
        if (value > 32'(DISPLAY_MAX)) begin
            return DISPLAY_MAX;
        end
        return value[15:0];
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter and a
// one-cycle pulse on the rising edge of the accepted (debounced) level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clock_100Mhz,
    input  logic reset_n,
    input  logic btn_raw,
    output logic step_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] stable_cnt;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
        end
    end

    // Accept a new level only after it has differed from the accepted level
    // for DEBOUNCE_CYCLES consecutive cycles; any return to the old level
    // restarts the count.
    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            level      <= 1'b0;
            stable_cnt <= '0;
        end else if (sync_2 == level) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CNT_LAST) begin
            level      <= sync_2;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + CNT_W'(1);
        end
    end

    // One-cycle pulse when the accepted level goes high.
    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            level_d    <= 1'b0;
            step_pulse <= 1'b0;
        end else begin
            level_d    <= level;
            step_pulse <= level & ~level_d;
        end
    end

endmodule

// File: rtl/reg_view_ctrl.sv
// Register-viewer controller: steps a register index with two buttons,
// reads the selected register and presents it clamped to 0..9999.
//
// Read port handshake: a read completes in the cycle where rd_req and
// rd_ack are both 1, and rd_data is taken in that same cycle. rd_addr is
// held stable while rd_req is 1. rd_ack while rd_req is 0 is ignored. If no
// ack arrives within READ_TIMEOUT cycles of rd_req rising, rd_req drops and
// the read is abandoned.
module reg_view_ctrl
    import reg_view_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REFRESH_CYCLES  = 10_000_000,
    parameter int READ_TIMEOUT    = 255,
    parameter int NUM_REGS        = 32
) (
    input  logic        clock_100Mhz,
    input  logic        reset_n,
    input  logic        btn_next,
    input  logic        btn_prev,
    output logic        rd_req,
    output logic [4:0]  rd_addr,
    input  logic        rd_ack,
    input  logic [31:0] rd_data,
    output logic [4:0]  reg_index,
    output logic [15:0] displayed_number,
    output logic        overflow,
    output logic        stale,
    output logic [1:0]  dbg_state
);

    localparam int REF_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int WAIT_W = (READ_TIMEOUT > 1) ? $clog2(READ_TIMEOUT) : 1;
    localparam logic [REF_W-1:0]     REF_LAST  = REF_W'(REFRESH_CYCLES - 1);
    localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(READ_TIMEOUT - 1);
    localparam logic [REG_IDX_W-1:0] IDX_LAST  = REG_IDX_W'(NUM_REGS - 1);

    logic                 next_pulse;
    logic                 prev_pulse;
    logic                 step;
    logic [REG_IDX_W-1:0] idx_next;
    view_state_t          state;
    logic                 pending;
    logic [REF_W-1:0]     refresh_cnt;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [31:0]          data_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_next (
        .clock_100Mhz(clock_100Mhz),
        .reset_n     (reset_n),
        .btn_raw     (btn_next),
        .step_pulse  (next_pulse)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_prev (
        .clock_100Mhz(clock_100Mhz),
        .reset_n     (reset_n),
        .btn_raw     (btn_prev),
        .step_pulse  (prev_pulse)
    );

    // Next index with wrap-around; simultaneous next and prev cancel.
    always_comb begin
        step     = next_pulse ^ prev_pulse;
        idx_next = reg_index;
        if (next_pulse && !prev_pulse) begin
            idx_next = (reg_index == IDX_LAST) ? '0 : reg_index + REG_IDX_W'(1);
        end else if (prev_pulse && !next_pulse) begin
            idx_next = (reg_index == '0) ? IDX_LAST : reg_index - REG_IDX_W'(1);
        end
    end

    // The index follows the buttons in every state.
    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            reg_index <= '0;
        end else begin
            reg_index <= idx_next;
        end
    end

    // Read sequencer: issues reads on steps, pending steps and refresh,
    // captures or abandons them, and drives the display outputs.
    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state            <= ST_REQ;
            rd_req           <= 1'b0;
            rd_addr          <= '0;
            displayed_number <= '0;
            overflow         <= 1'b0;
            stale            <= 1'b0;
            pending          <= 1'b0;
            refresh_cnt      <= '0;
            wait_cnt         <= '0;
            data_q           <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (step || pending || (refresh_cnt == REF_LAST)) begin
                        state       <= ST_REQ;
                        rd_req      <= 1'b1;
                        rd_addr     <= idx_next;
                        wait_cnt    <= '0;
                        pending     <= 1'b0;
                        refresh_cnt <= '0;
                    end else begin
                        refresh_cnt <= refresh_cnt + REF_W'(1);
                    end
                end

                ST_REQ: begin
                    if (!rd_req) begin
                        // First cycle out of reset: start the read here,
                        // already pointing at any index that moves now.
                        rd_req   <= 1'b1;
                        rd_addr  <= idx_next;
                        wait_cnt <= '0;
                    end else begin
                        if (step) begin
                            pending <= 1'b1;
                        end
                        if (rd_ack) begin
                            rd_req <= 1'b0;
                            data_q <= rd_data;
                            state  <= ST_CAPTURE;
                        end else if (wait_cnt == WAIT_LAST) begin
                            rd_req      <= 1'b0;
                            stale       <= 1'b1;
                            refresh_cnt <= '0;
                            state       <= ST_IDLE;
                        end else begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    end
                end

                ST_CAPTURE: begin
                    if (step) begin
                        pending <= 1'b1;
                    end
                    displayed_number <= clamp_display(data_q);
                    overflow         <= (data_q > 32'(DISPLAY_MAX));
                    stale            <= 1'b0;
                    refresh_cnt      <= '0;
                    state            <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_reg_view_ctrl.sv
// Directed-sequence bench with a behavioural register file responder and a
// reference model of the clamp/overflow/index rules.
module tb_reg_view_ctrl;
    import reg_view_pkg::*;

    logic        clock_100Mhz;
    logic        reset_n;
    logic        btn_next;
    logic        btn_prev;
    logic        rd_req;
    logic [4:0]  rd_addr;
    logic        rd_ack;
    logic [31:0] rd_data;
    logic [4:0]  reg_index;
    logic [15:0] displayed_number;
    logic        overflow;
    logic        stale;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [32];
    logic [4:0]  got_q [$];
    logic [4:0]  exp_q [$];
    int          ack_delay = 2;
    logic        ack_en = 1'b1;

    reg_view_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .REFRESH_CYCLES (64),
        .READ_TIMEOUT   (8),
        .NUM_REGS       (32)
    ) dut (
        .clock_100Mhz    (clock_100Mhz),
        .reset_n         (reset_n),
        .btn_next        (btn_next),
        .btn_prev        (btn_prev),
        .rd_req          (rd_req),
        .rd_addr         (rd_addr),
        .rd_ack          (rd_ack),
        .rd_data         (rd_data),
        .reg_index       (reg_index),
        .displayed_number(displayed_number),
        .overflow        (overflow),
        .stale           (stale),
        .dbg_state       (dbg_state)
    );

    // Clock and watchdog
    initial clock_100Mhz = 1'b0;
    always #5 clock_100Mhz = ~clock_100Mhz;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // Reference model: plain decimal saturation
    function automatic logic [31:0] model_disp(input logic [31:0] v);
        return (v > 32'd9999) ? 32'd9999 : v;
    endfunction

    function automatic logic [31:0] model_ovf(input logic [31:0] v);
        return (v > 32'd9999) ? 32'd1 : 32'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Register file responder: acks ack_delay cycles into a request
    initial begin
        int dcnt;
        dcnt    = 0;
        rd_ack  = 1'b0;
        rd_data = '0;
        forever begin
            @(posedge clock_100Mhz);
            #2;
            if (rd_ack) begin
                rd_ack = 1'b0;
            end else if (rd_req && ack_en) begin
                if (dcnt >= ack_delay) begin
                    rd_ack  = 1'b1;
                    rd_data = mem[rd_addr];
                    got_q.push_back(rd_addr);
                    dcnt = 0;
                end else begin
                    dcnt++;
                end
            end else if (!rd_req) begin
                dcnt = 0;
            end
        end
    end

    // Driver and wait helpers
    task automatic press(input logic do_next, input logic do_prev, input int hold);
        @(negedge clock_100Mhz);
        btn_next = do_next;
        btn_prev = do_prev;
        repeat (hold) @(negedge clock_100Mhz);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        repeat (12) @(negedge clock_100Mhz);
    endtask

    task automatic wait_req_level(input string tag, input logic val, input int max);
        int n;
        n = 0;
        while (rd_req !== val && n < max) begin
            @(negedge clock_100Mhz);
            n++;
        end
        check(tag, 32'(rd_req), 32'(val));
    endtask

    task automatic wait_handshake(input string tag, input int max, output logic [4:0] addr);
        int n;
        n = 0;
        while (!(rd_req && rd_ack) && n < max) begin
            @(negedge clock_100Mhz);
            n++;
        end
        check(tag, 32'(rd_req && rd_ack), 32'd1);
        addr = rd_addr;
    endtask

    // Directed sequence
    initial begin
        logic [4:0]  addr;
        logic [31:0] v;
        logic [31:0] prev_disp;
        logic [31:0] mem3_old;
        int          exp_idx;
        int          cnt0;
        int          high_cycles;
        logic        changed;

        reset_n  = 1'b0;
        btn_next = 1'b0;
        btn_prev = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        mem[0] = 32'd1234;
        mem[3] = $urandom_range(1, 9999);

        // Reset state
        repeat (3) @(negedge clock_100Mhz);
        check("rst_rd_req", 32'(rd_req), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_reg_index", 32'(reg_index), 32'd0);
        check("rst_display", 32'(displayed_number), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_stale", 32'(stale), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_REQ));

        // 1: first read of register 0 right after reset release
        reset_n = 1'b1;
        @(negedge clock_100Mhz);
        check("t1_req_first_clk", 32'(rd_req), 32'd1);
        check("t1_addr", 32'(rd_addr), 32'd0);
        wait_handshake("t1_handshake", 20, addr);
        check("t1_hs_addr", 32'(addr), 32'd0);
        @(negedge clock_100Mhz);
        check("t1_req_drop", 32'(rd_req), 32'd0);
        @(negedge clock_100Mhz);
        check("t1_display", 32'(displayed_number), model_disp(mem[0]));
        check("t1_overflow", 32'(overflow), model_ovf(mem[0]));
        check("t1_stale", 32'(stale), 32'd0);

        // 2: prev at index 0 wraps to 31, short glitch is rejected
        exp_idx = (0 + 32 - 1) % 32;
        press(1'b0, 1'b1, 10);
        check("t2_index_wrap", 32'(reg_index), 32'(exp_idx));
        check("t2_read_addr", 32'(got_q[$]), 32'(exp_idx));
        check("t2_display", 32'(displayed_number), model_disp(mem[exp_idx]));
        check("t2_overflow", 32'(overflow), model_ovf(mem[exp_idx]));
        press(1'b1, 1'b0, 2);
        check("t2_glitch_index", 32'(reg_index), 32'(exp_idx));

        // 3: clamp boundaries, then randomized values via refresh reads
        mem[31] = 32'h0001_0000;
        repeat (90) @(negedge clock_100Mhz);
        check("t3_clamp_display", 32'(displayed_number), 32'd9999);
        check("t3_clamp_overflow", 32'(overflow), 32'd1);
        mem[31] = 32'd9999;
        repeat (90) @(negedge clock_100Mhz);
        check("t3_max_display", 32'(displayed_number), 32'd9999);
        check("t3_max_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 5; i++) begin
            case (i)
                0:       v = 32'd10000;
                1:       v = $urandom;
                default: v = $urandom_range(0, 12000);
            endcase
            mem[31] = v;
            repeat (90) @(negedge clock_100Mhz);
            check("t3_rand_display", 32'(displayed_number), model_disp(v));
            check("t3_rand_overflow", 32'(overflow), model_ovf(v));
        end

        // 4: withheld ack times out after 8 cycles, then recovers
        prev_disp = model_disp(mem[31]);
        ack_en = 1'b0;
        wait_req_level("t4_req_low", 1'b0, 50);
        wait_req_level("t4_req_rise", 1'b1, 150);
        high_cycles = 0;
        while (rd_req && high_cycles < 40) begin
            high_cycles++;
            @(negedge clock_100Mhz);
        end
        check("t4_timeout_len", 32'(high_cycles), 32'd8);
        check("t4_stale", 32'(stale), 32'd1);
        check("t4_display_held", 32'(displayed_number), prev_disp);
        ack_en = 1'b1;
        mem[31] = $urandom_range(0, 9999);
        repeat (90) @(negedge clock_100Mhz);
        check("t4_stale_clear", 32'(stale), 32'd0);
        check("t4_display", 32'(displayed_number), model_disp(mem[31]));

        // 5: steps during an outstanding read of register 3
        for (int i = 0; i < 4; i++) begin
            exp_idx = (exp_idx + 1) % 32;
            press(1'b1, 1'b0, 10);
        end
        check("t5_index", 32'(reg_index), 32'd3);
        ack_delay = 5;
        wait_handshake("t5_align", 200, addr);
        got_q.delete();
        exp_q.delete();
        exp_q.push_back(5'd3);
        exp_q.push_back(5'd3);
        mem3_old = mem[3];
        changed = 1'b0;
        for (int k = 1; k <= 111; k++) begin
            @(negedge clock_100Mhz);
            if (k == 61) btn_next = 1'b1;
            if (k == 64) btn_prev = 1'b1;
            if (k == 71) btn_next = 1'b0;
            if (k == 74) btn_prev = 1'b0;
            if (k == 70) begin
                check("t5_mid_index", 32'(reg_index), 32'd4);
                check("t5_mid_addr", 32'(rd_addr), 32'd3);
                check("t5_mid_req", 32'(rd_req), 32'd1);
            end
            if (k == 75) begin
                check("t5_inflight_display", 32'(displayed_number), model_disp(mem3_old));
            end
            if (got_q.size() == 1 && !changed) begin
                mem[3] = $urandom_range(1, 9999);
                changed = 1'b1;
            end
        end
        check("t5_read_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check("t5_read_addr", 32'(got_q[i]), 32'(exp_q[i]));
        end
        check("t5_final_index", 32'(reg_index), 32'd3);
        check("t5_reread_display", 32'(displayed_number), model_disp(mem[3]));

        // Simultaneous next and prev cancel: no index change, no read
        ack_delay = 2;
        wait_handshake("t5_cancel_align", 200, addr);
        cnt0 = got_q.size();
        press(1'b1, 1'b1, 10);
        check("t5_cancel_index", 32'(reg_index), 32'd3);
        check("t5_cancel_reads", 32'(got_q.size()), 32'(cnt0));

        // 6: asynchronous reset in the middle of a read
        wait_req_level("t6_req_rise", 1'b1, 200);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rd_req", 32'(rd_req), 32'd0);
        check("t6_reg_index", 32'(reg_index), 32'd0);
        check("t6_display", 32'(displayed_number), 32'd0);
        check("t6_rd_addr", 32'(rd_addr), 32'd0);
        check("t6_stale", 32'(stale), 32'd0);
        @(negedge clock_100Mhz);
        reset_n = 1'b1;
        @(negedge clock_100Mhz);
        check("t6_req_restart", 32'(rd_req), 32'd1);
        wait_handshake("t6_handshake", 20, addr);
        check("t6_hs_addr", 32'(addr), 32'd0);
        repeat (2) @(negedge clock_100Mhz);
        check("t6_display_after", 32'(displayed_number), model_disp(mem[0]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
